count_monitor: RTL and testbench

//  Downstream consumer of the 4-bit free-running counter value. Checks that the count

---
 rtl/count_mon_pkg.sv | 19 +
 rtl/count_monitor_sat_counter.sv | 25 ++
 rtl/count_monitor.sv | 171 +++++++++++++++++
 tb/tb_count_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and default parameters for the count monitor.
//   cm_state_t      : monitor FSM state encoding, also exported on the state port
//   DEF_*           : default parameter values used by count_monitor
package count_mon_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRACK = 3'd1,
        CLEAR = 3'd2,
        WAIT0 = 3'd3,
        ERROR = 3'd4
    } cm_state_t;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_TERMINAL    = 10;
    localparam int DEF_STUCK_LIMIT = 3;
    localparam int DEF_WRAP_W      = 8;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock, all logic on posedge
//   inc : advance by one, ignored once q is all-ones
//   clr : synchronous clear, takes priority over inc
//   q   : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // NOTE: clr is the only reset path; the parent folds its synchronous reset
    // into clr, so this block needs no separate reset port.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Observes a free-running counter, checks the count sequence and counts
// completed periods. A registered clear request (clr) goes back to the counter
// once the terminal value is seen, so there is no combinational
// count->clear->count loop.
//   clk       : clock, all logic on posedge
//   i_rst     : synchronous reset, active-high, highest priority
//   en        : sample qualifier; low freezes everything except err_clr handling
//   count     : observed counter value
//   err_clr   : clears the sticky error flags; leaves ERROR for IDLE
//   clr       : one-cycle registered clear request to the counter
//   wrap_cnt  : completed periods, saturating
//   err_skip  : sticky, illegal step in the sequence
//   err_stuck : sticky, count held for STUCK_LIMIT samples
//   state     : current FSM state (debug)
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TERMINAL    = DEF_TERMINAL,
    parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
    parameter int WRAP_W      = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  count,
    input  logic              err_clr,
    output logic              clr,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_skip,
    output logic              err_stuck,
    output logic [2:0]        state
);

    localparam int STUCK_W = (STUCK_LIMIT > 2) ? $clog2(STUCK_LIMIT) : 1;
    // stuck_ctr counts repeats after the first sample of a value, so the
    // STUCK_LIMIT-th equal sample arrives while the counter holds STUCK_LIMIT-2.
    localparam logic [STUCK_W-1:0] STUCK_THR = STUCK_W'(STUCK_LIMIT - 2);

    cm_state_t          state_q;
    logic [WIDTH-1:0]   prev;
    logic [STUCK_W-1:0] stuck_ctr;

    logic is_term;
    logic is_next;
    logic is_same;
    logic is_zero;
    logic wrap_inc;
    logic stuck_inc;
    logic stuck_clr;
    logic skip_set;
    logic stuck_set;

    // Successor wraps naturally at 2**WIDTH, so all-ones -> 0 is a legal step.
    assign is_term = (count == WIDTH'(TERMINAL));
    assign is_next = (count == prev + WIDTH'(1));
    assign is_same = (count == prev);
    assign is_zero = (count == '0);

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wrap_inc  = 1'b0;
        stuck_inc = 1'b0;
        stuck_clr = i_rst;
        skip_set  = 1'b0;
        stuck_set = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: stuck_clr = 1'b1;
                TRACK: begin
                    if (!is_term) begin
                        if (is_next) begin
                            stuck_clr = 1'b1;
                        end else if (is_same) begin
                            stuck_inc = 1'b1;
                            stuck_set = (stuck_ctr >= STUCK_THR);
                        end else begin
                            skip_set = 1'b1;
                        end
                    end
                end
                WAIT0: begin
                    if (is_zero) begin
                        wrap_inc  = 1'b1;
                        stuck_clr = 1'b1;
                    end else begin
                        skip_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            clr       <= 1'b0;
            prev      <= '0;
            err_skip  <= 1'b0;
            err_stuck <= 1'b0;
        end else begin
            // NOTE: non-blocking default; the TRACK branch below overrides it,
            // and the last non-blocking write in the block wins, which makes
            // clr a single-cycle pulse without a separate clear step.
            clr <= 1'b0;

            // A set on the same edge as err_clr wins.
            err_skip  <= skip_set  | (err_skip  & ~err_clr);
            err_stuck <= stuck_set | (err_stuck & ~err_clr);

            case (state_q)
                IDLE: begin
                    if (en) begin
                        prev    <= count;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (en) begin
                        if (is_term) begin
                            clr     <= 1'b1;
                            state_q <= CLEAR;
                        end else if (is_next) begin
                            prev <= count;
                        end else if (!is_same) begin
                            state_q <= ERROR;
                        end
                    end
                end
                // The counter has already advanced to TERMINAL+1; that sample
                // carries no information and is dropped regardless of en.
                CLEAR: state_q <= WAIT0;
                WAIT0: begin
                    if (en) begin
                        if (is_zero) begin
                            prev    <= '0;
                            state_q <= TRACK;
                        end else begin
                            state_q <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    if (err_clr) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(WRAP_W)) u_wrap_ctr (
        .clk (clk),
        .inc (wrap_inc),
        .clr (i_rst),
        .q   (wrap_cnt)
    );

    sat_counter #(.W(STUCK_W)) u_stuck_ctr (
        .clk (clk),
        .inc (stuck_inc),
        .clr (stuck_clr),
        .q   (stuck_ctr)
    );

    assign state = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor. A second instance with WRAP_W=2 shares the
// stimulus to exercise wrap_cnt saturation.
module tb_count_monitor;
    import count_mon_pkg::*;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       en;
    logic [3:0] count;
    logic       err_clr;

    logic       clr;
    logic [7:0] wrap_cnt;
    logic       err_skip;
    logic       err_stuck;
    logic [2:0] state;

    logic       clr_b;
    logic [1:0] wrap_cnt_b;
    logic       err_skip_b;
    logic       err_stuck_b;
    logic [2:0] state_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_monitor dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .en        (en),
        .count     (count),
        .err_clr   (err_clr),
        .clr       (clr),
        .wrap_cnt  (wrap_cnt),
        .err_skip  (err_skip),
        .err_stuck (err_stuck),
        .state     (state)
    );

    count_monitor #(.WRAP_W(2)) dut_w2 (
        .clk       (clk),
        .i_rst     (i_rst),
        .en        (en),
        .count     (count),
        .err_clr   (err_clr),
        .clr       (clr_b),
        .wrap_cnt  (wrap_cnt_b),
        .err_skip  (err_skip_b),
        .err_stuck (err_stuck_b),
        .state     (state_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one edge, then settle so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] c);
        en    = e;
        count = c;
        tick();
    endtask

    // One full legal period starting from TRACK with prev=0.
    task automatic period();
        for (int c = 1; c <= 10; c++) drive(1'b1, 4'(c));
        drive(1'b1, 4'd11);
        drive(1'b1, 4'd0);
    endtask

    initial begin
        i_rst   = 1'b1;
        en      = 1'b0;
        count   = 4'd0;
        err_clr = 1'b0;
        tick();
        tick();
        check("rst_clr",       32'(clr),       32'd0);
        check("rst_wrap",      32'(wrap_cnt),  32'd0);
        check("rst_skip",      32'(err_skip),  32'd0);
        check("rst_stuck",     32'(err_stuck), 32'd0);
        check("rst_state",     32'(state),     32'(IDLE));
        i_rst = 1'b0;

        // 1: first period with clr handshake
        drive(1'b1, 4'd0);
        check("t1_track",      32'(state),     32'(TRACK));
        for (int c = 1; c <= 9; c++) drive(1'b1, 4'(c));
        check("t1_no_clr_at9", 32'(clr),       32'd0);
        drive(1'b1, 4'd10);
        check("t1_clr_hi",     32'(clr),       32'd1);
        check("t1_clear",      32'(state),     32'(CLEAR));
        drive(1'b1, 4'd11);
        check("t1_clr_lo",     32'(clr),       32'd0);
        check("t1_wait0",      32'(state),     32'(WAIT0));
        drive(1'b1, 4'd0);
        check("t1_wrap1",      32'(wrap_cnt),  32'd1);
        check("t1_track2",     32'(state),     32'(TRACK));

        // 2: nine more periods -> ten total; narrow counter saturates at 3
        for (int p = 0; p < 9; p++) period();
        check("t2_wrap10",     32'(wrap_cnt),  32'd10);
        check("t2_wrap_sat",   32'(wrap_cnt_b),32'd3);
        check("t2_skip",       32'(err_skip),  32'd0);
        check("t2_stuck",      32'(err_stuck), 32'd0);

        // 3: skip 4 -> 6
        drive(1'b1, 4'd1);
        drive(1'b1, 4'd2);
        drive(1'b1, 4'd3);
        drive(1'b1, 4'd4);
        drive(1'b1, 4'd6);
        check("t3_skip",       32'(err_skip),  32'd1);
        check("t3_error",      32'(state),     32'(ERROR));
        check("t3_clr",        32'(clr),       32'd0);
        drive(1'b1, 4'd7);
        check("t3_hold_err",   32'(state),     32'(ERROR));
        err_clr = 1'b1;
        drive(1'b1, 4'd8);
        err_clr = 1'b0;
        check("t3_skip_clr",   32'(err_skip),  32'd0);
        check("t3_idle",       32'(state),     32'(IDLE));

        // 4: stuck detection
        drive(1'b1, 4'd3);
        drive(1'b1, 4'd4);
        drive(1'b1, 4'd5);
        drive(1'b1, 4'd5);
        check("t4_stuck_2nd",  32'(err_stuck), 32'd0);
        drive(1'b1, 4'd5);
        check("t4_stuck_3rd",  32'(err_stuck), 32'd1);
        check("t4_track",      32'(state),     32'(TRACK));
        err_clr = 1'b1;
        drive(1'b0, 4'd5);
        err_clr = 1'b0;
        check("t4_stuck_clr",  32'(err_stuck), 32'd0);
        drive(1'b1, 4'd6);
        drive(1'b0, 4'd9);
        drive(1'b1, 4'd6);
        check("t4_en0_stuck",  32'(err_stuck), 32'd0);
        check("t4_en0_skip",   32'(err_skip),  32'd0);
        check("t4_en0_state",  32'(state),     32'(TRACK));

        // 5: bad value in WAIT0, then reset during the clr cycle
        for (int c = 7; c <= 10; c++) drive(1'b1, 4'(c));
        drive(1'b1, 4'd11);
        check("t5_wait0",      32'(state),     32'(WAIT0));
        drive(1'b1, 4'd7);
        check("t5_skip",       32'(err_skip),  32'd1);
        check("t5_error",      32'(state),     32'(ERROR));
        err_clr = 1'b1;
        drive(1'b0, 4'd0);
        err_clr = 1'b0;
        drive(1'b1, 4'd0);
        for (int c = 1; c <= 10; c++) drive(1'b1, 4'(c));
        check("t5_clr_hi",     32'(clr),       32'd1);
        i_rst = 1'b1;
        drive(1'b1, 4'd11);
        i_rst = 1'b0;
        check("t5_rst_clr",    32'(clr),       32'd0);
        check("t5_rst_idle",   32'(state),     32'(IDLE));
        check("t5_rst_wrap",   32'(wrap_cnt),  32'd0);

        // 6: set and clear on the same edge; set wins
        drive(1'b1, 4'd2);
        drive(1'b1, 4'd3);
        err_clr = 1'b1;
        drive(1'b1, 4'd5);
        err_clr = 1'b0;
        check("t6_set_wins",   32'(err_skip),  32'd1);
        check("t6_error",      32'(state),     32'(ERROR));

        // en=0 holds WAIT0 and blocks the skip check there
        err_clr = 1'b1;
        drive(1'b0, 4'd0);
        err_clr = 1'b0;
        drive(1'b1, 4'd0);
        for (int c = 1; c <= 10; c++) drive(1'b1, 4'(c));
        drive(1'b1, 4'd11);
        drive(1'b0, 4'd5);
        check("t7_hold_wait0", 32'(state),     32'(WAIT0));
        check("t7_hold_skip",  32'(err_skip),  32'd0);
        drive(1'b1, 4'd0);
        check("t7_wrap1",      32'(wrap_cnt),  32'd1);
        check("t7_track",      32'(state),     32'(TRACK));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
